// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable, prescaled down counter with pause, abort, auto-reload
// and a held completion flag.
module down_counter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done_valid,
  input  logic             done_ack
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  typedef enum logic [2:0] {IDLE, LOADED, RUN, PAUSED, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic [PW-1:0] pre_q, pre_d;
  logic tc_q, tc_d, done_q, done_d;
  logic tick, last;
  assign tick = pre_q == PRE_MAX;
  assign last = count_q <= WIDTH'(1);
  // Leaving PAUSED with pause low behaves like a RUN cycle, so the held prescaler
  // advances on that same edge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    case (state_q)
      IDLE, LOADED:
        if (load_valid) begin
          count_d  = load_value;
          reload_d = load_value;
          state_d  = LOADED;
        end else if (state_q == LOADED && start) begin
          state_d = RUN;
          pre_d   = '0;
        end
      RUN, PAUSED:
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSED;
        end else begin
          state_d = RUN;
          pre_d   = tick ? '0 : pre_q + PW'(1);
          if (tick && !last) count_d = count_q - WIDTH'(1);
          if (tick && last) begin
            tc_d    = 1'b1;
            count_d = auto_reload ? reload_q : '0;
            state_d = auto_reload ? RUN : DONE;
            done_d  = !auto_reload;
          end
        end
      DONE:
        if (done_ack) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end
  assign count      = count_q;
  assign busy       = state_q == RUN || state_q == PAUSED;
  assign load_ready = state_q == IDLE || state_q == LOADED;
  assign tc         = tc_q;
  assign done_valid = done_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed tests; observations packed as
// {count[3:0], busy, tc, done_valid, load_ready}.
module tb_down_counter_timer;
  logic clk = 1'b0, rst = 1'b0;
  logic load_valid = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic auto_reload = 1'b0, done_ack = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] count1, count3;
  logic load_ready1, busy1, tc1, done1, load_ready3, busy3, tc3, done3;
  int vectors = 0, errors = 0;
  logic [7:0] obs1, obs3;
  assign obs1 = {count1, busy1, tc1, done1, load_ready1};
  assign obs3 = {count3, busy3, tc3, done3, load_ready3};

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready1), .start(start), .pause(pause), .abort(abort),
    .auto_reload(auto_reload), .count(count1), .busy(busy1), .tc(tc1),
    .done_valid(done1), .done_ack(done_ack)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready3), .start(start), .pause(pause), .abort(abort),
    .auto_reload(auto_reload), .count(count3), .busy(busy3), .tc(tc3),
    .done_valid(done3), .done_ack(done_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_start(input logic [3:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (obs1 !== 8'h01) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs1, 8'h01);
    end
    #5 rst = 1'b1;
  endtask

  task automatic test_oneshot();
    logic [7:0] exp [5] = '{8'h38, 8'h28, 8'h18, 8'h06, 8'h02};
    load_valid = 1'b1;
    load_value = 4'd3;
    step();
    load_valid = 1'b0;
    vectors++;
    if (obs1 !== 8'h31) begin
      errors++;
      $display("FAIL oneshot_loaded got %h want %h", obs1, 8'h31);
    end
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      vectors++;
      if (obs1 !== exp[i]) begin
        errors++;
        $display("FAIL oneshot_edge%0d got %h want %h", i, obs1, exp[i]);
      end
    end
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    vectors++;
    if (obs1 !== 8'h01) begin
      errors++;
      $display("FAIL oneshot_ack got %h want %h", obs1, 8'h01);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp [4] = '{8'h18, 8'h2c, 8'h18, 8'h2c};
    auto_reload = 1'b1;
    load_start(4'd2);
    vectors++;
    if (obs1 !== 8'h28) begin
      errors++;
      $display("FAIL reload_start got %h want %h", obs1, 8'h28);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (obs1 !== exp[i]) begin
        errors++;
        $display("FAIL reload_edge%0d got %h want %h", i, obs1, exp[i]);
      end
    end
    auto_reload = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (obs1 !== 8'h01) begin
      errors++;
      $display("FAIL reload_abort got %h want %h", obs1, 8'h01);
    end
  endtask

  task automatic test_pause();
    load_start(4'd9);
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (obs1 !== 8'h68) begin
      errors++;
      $display("FAIL pause_pre got %h want %h", obs1, 8'h68);
    end
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (obs1 !== 8'h68) begin
        errors++;
        $display("FAIL pause_hold%0d got %h want %h", i, obs1, 8'h68);
      end
    end
    pause = 1'b0;
    step();
    vectors++;
    if (obs1 !== 8'h58) begin
      errors++;
      $display("FAIL pause_resume got %h want %h", obs1, 8'h58);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_zero_load();
    load_start(4'd0);
    vectors++;
    if (obs1 !== 8'h08) begin
      errors++;
      $display("FAIL zero_run got %h want %h", obs1, 8'h08);
    end
    step();
    vectors++;
    if (obs1 !== 8'h06) begin
      errors++;
      $display("FAIL zero_tick got %h want %h", obs1, 8'h06);
    end
    step();
    vectors++;
    if (obs1 !== 8'h02) begin
      errors++;
      $display("FAIL zero_hold got %h want %h", obs1, 8'h02);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (obs1 !== 8'h02) begin
      errors++;
      $display("FAIL done_abort_ignored got %h want %h", obs1, 8'h02);
    end
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
  endtask

  task automatic test_load_start_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (obs1 !== 8'h01) begin
      errors++;
      $display("FAIL idle_start_ignored got %h want %h", obs1, 8'h01);
    end
    load_valid = 1'b1;
    load_value = 4'd5;
    step();
    load_value = 4'd7;
    start = 1'b1;
    step();
    load_valid = 1'b0;
    vectors++;
    if (obs1 !== 8'h71) begin
      errors++;
      $display("FAIL load_beats_start got %h want %h", obs1, 8'h71);
    end
    step();
    start = 1'b0;
    step();
    vectors++;
    if (obs1 !== 8'h68) begin
      errors++;
      $display("FAIL run_after_reload got %h want %h", obs1, 8'h68);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (obs1 !== 8'h01) begin
      errors++;
      $display("FAIL run_abort got %h want %h", obs1, 8'h01);
    end
  endtask

  task automatic test_prescale();
    logic [3:0] exp [4] = '{4'd2, 4'd2, 4'd1, 4'd1};
    rst = 1'b0;
    #2 rst = 1'b1;
    load_start(4'd2);
    vectors++;
    if (obs3 !== 8'h28) begin
      errors++;
      $display("FAIL pre_start got %h want %h", obs3, 8'h28);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (count3 !== exp[i]) begin
        errors++;
        $display("FAIL pre_edge%0d got %0d want %0d", i, count3, exp[i]);
      end
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs3 !== 8'h01) begin
      errors++;
      $display("FAIL pre_async_reset got %h want %h", obs3, 8'h01);
    end
    #2 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_pause();
    test_zero_load();
    test_load_start_abort();
    test_prescale();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of count and load value.
REQ-002 SHALL have parameter PRESCALE, default 1 (legal 1..256): clock cycles per count tick.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port load_valid, input, 1: load request.
REQ-006 SHALL have port load_value, input, WIDTH: start value, sampled on load handshake.
REQ-007 SHALL have port load_ready, output, 1: load accepted when high together with load_valid.
REQ-008 SHALL have port start, input, 1: begin counting.
REQ-009 SHALL have port pause, input, 1: level-sensitive hold.
REQ-010 SHALL have port abort, input, 1: cancel the run.
REQ-011 SHALL have port auto_reload, input, 1: reload instead of finishing at terminal count.
REQ-012 SHALL have port count, output, WIDTH: current registered count.
REQ-013 SHALL have port busy, output, 1: high in RUN or PAUSED.
REQ-014 SHALL have port tc, output, 1: one-cycle registered terminal-count pulse.
REQ-015 SHALL have port done_valid, output, 1: completion flag, held until acknowledged.
REQ-016 SHALL have port done_ack, input, 1: acknowledges done_valid.

Function
REQ-017 SHALL implement states IDLE, LOADED, RUN, PAUSED, DONE.
REQ-018 SHALL drive load_ready high only in IDLE and LOADED.
REQ-019 On load_valid and load_ready, SHALL set count and an internal reload register to load_value, then enter LOADED; this applies to any value, including 0.
REQ-020 In LOADED, when start is high and load_valid is low, SHALL enter RUN and clear the prescaler.
REQ-021 In LOADED, when load_valid and start are both high, SHALL perform the load, stay in LOADED and ignore start.
REQ-022 In IDLE, RUN, PAUSED and DONE, SHALL ignore start.
REQ-023 In RUN, SHALL generate a tick on every PRESCALE-th cycle; the first decrement occurs at edge N+PRESCALE when start is sampled at edge N.
REQ-024 On a tick with count > 1, SHALL decrement count by 1.
REQ-025 On a tick with count <= 1 and auto_reload high, SHALL load count from the reload register, pulse tc for one cycle, stay in RUN and keep done_valid low.
REQ-026 On a tick with count <= 1 and auto_reload low, SHALL set count to 0, pulse tc for one cycle and enter DONE.
REQ-027 SHALL never wrap count below 0.
REQ-028 In RUN with pause high, SHALL enter PAUSED; pause SHALL take priority over a coincident tick, so no decrement occurs on that edge.
REQ-029 In PAUSED, SHALL hold count and the prescaler; when pause goes low, SHALL return to RUN and resume the prescaler from its held value.
REQ-030 In RUN or PAUSED with abort high, SHALL clear count to 0 and enter IDLE without tc or done_valid; abort SHALL take priority over pause and tick.
REQ-031 In DONE, SHALL hold done_valid high and count at 0 until done_ack is high, then enter IDLE and drop done_valid on the same edge.
REQ-032 SHALL ignore done_ack outside DONE.
REQ-033 SHALL ignore abort in IDLE, LOADED and DONE.

Reset
REQ-034 While rst is low, SHALL asynchronously force state IDLE and clear count, reload register, prescaler, tc and done_valid to 0; busy is therefore 0 and load_ready is 1.
REQ-035 Assertion of rst mid-run SHALL take effect immediately, without waiting for a clock edge.
REQ-036 After rst deasserts, SHALL accept a load on the first rising edge.

Verification (WIDTH=4, PRESCALE=1 unless stated)
REQ-037 Load 3, then start -> count reads 3,2,1,0 on successive edges; tc high only in the cycle count becomes 0; done_valid stays high until done_ack, then the block returns to IDLE.
REQ-038 auto_reload=1, load 2, start -> count sequence 2,1,2,1,2; tc pulses every 2 cycles; done_valid never asserts.
REQ-039 Load 9, start, then pause high for 5 cycles while count=6 -> count stays 6 and busy stays 1; counting resumes to 5 on the first edge after pause drops.
REQ-040 Load 0, start -> on the first tick count stays 0, tc pulses once and the block enters DONE with no wrap to 15.
REQ-041 PRESCALE=3, load 2, start -> count changes every 3rd cycle; rst pulsed low mid-run clears count and busy immediately without a clock edge.
REQ-042 In LOADED, load_valid with load_value=7 together with start -> count becomes 7 and state stays LOADED; a later abort while in RUN clears count to 0 with tc=0 and done_valid=0.
